// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges pipeline WB writes and buffered mul/div results onto one RF port.
// Optional starvation guard compiled only when WB_STARVE_GUARD_EN is defined.
module wb_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        Regfile_weW,
  input  logic [4:0]  writeRegAddrW,
  input  logic [31:0] resultW,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_stall,
  output logic        hold_busy
);

  logic        hold_v, hold_v_d;
  logic [4:0]  hold_addr, hold_addr_d;
  logic [31:0] hold_data, hold_data_d;
  logic        rf_we_d;
  logic [4:0]  rf_waddr_d;
  logic [31:0] rf_wdata_d;
  logic        pipe_req, grant_hold, grant_pipe, supersede, accept;

  assign md_ready  = ~hold_v;
  assign hold_busy = hold_v;
  assign accept    = md_valid & md_ready;
  assign pipe_req  = Regfile_weW & (writeRegAddrW != 5'd0);

  // Grant priority; during a stall cycle the pipeline is ignored and replays next cycle.
  always_comb begin
    grant_hold = 1'b0;
    grant_pipe = 1'b0;
    if (wb_stall) begin
      grant_hold = hold_v;
    end else if (pipe_req) begin
      grant_pipe = 1'b1;
    end else begin
      grant_hold = hold_v;
    end
  end

  assign supersede = grant_pipe & hold_v & (writeRegAddrW == hold_addr);

  always_comb begin
    hold_v_d    = hold_v;
    hold_addr_d = hold_addr;
    hold_data_d = hold_data;
    if (grant_hold || supersede) begin
      hold_v_d = 1'b0;
    end
    // Results for r0 are accepted but dropped.
    if (accept && (md_addr != 5'd0)) begin
      hold_v_d    = 1'b1;
      hold_addr_d = md_addr;
      hold_data_d = md_data;
    end
  end

  always_comb begin
    rf_we_d    = grant_hold | grant_pipe;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    if (grant_hold) begin
      rf_waddr_d = hold_addr;
      rf_wdata_d = hold_data;
    end else if (grant_pipe) begin
      rf_waddr_d = writeRegAddrW;
      rf_wdata_d = resultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v    <= 1'b0;
      hold_addr <= 5'd0;
      hold_data <= 32'd0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
    end else begin
      hold_v    <= hold_v_d;
      hold_addr <= hold_addr_d;
      hold_data <= hold_data_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      rf_wdata  <= rf_wdata_d;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  logic [1:0] starve_cnt, starve_cnt_d;
  logic       wb_stall_d;

  // Count cycles the buffered result loses to the pipeline; the third loss forces a stall.
  always_comb begin
    starve_cnt_d = starve_cnt;
    wb_stall_d   = 1'b0;
    if (wb_stall || grant_hold || supersede) begin
      starve_cnt_d = 2'd0;
    end else if (hold_v && grant_pipe) begin
      if (starve_cnt == 2'd2) begin
        starve_cnt_d = 2'd3;
        wb_stall_d   = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 2'd0;
      wb_stall   <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_d;
      wb_stall   <= wb_stall_d;
    end
  end
`else
  assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; follows WB_STARVE_GUARD_EN if defined.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        Regfile_weW;
  logic [4:0]  writeRegAddrW;
  logic [31:0] resultW;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        hold_busy;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .Regfile_weW  (Regfile_weW),
    .writeRegAddrW(writeRegAddrW),
    .resultW      (resultW),
    .md_valid     (md_valid),
    .md_ready     (md_ready),
    .md_addr      (md_addr),
    .md_data      (md_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_stall     (wb_stall),
    .hold_busy    (hold_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Regfile_weW   = 1'b0;
    writeRegAddrW = 5'd0;
    resultW       = 32'd0;
    md_valid      = 1'b0;
    md_addr       = 5'd0;
    md_data       = 32'd0;
  endtask

  task automatic test_reset();
    total++;
    if ({rf_we, rf_waddr, rf_wdata, wb_stall, hold_busy} !== 40'd0) begin
      bad++;
      $display("FAIL reset_outputs got we=%0b a=%0d d=%h st=%0b hb=%0b want all 0",
               rf_we, rf_waddr, rf_wdata, wb_stall, hold_busy);
    end
    total++;
    if (md_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_md_ready got %0b want 1", md_ready);
    end
    #2 rst = 1'b1;
    tick();
    total++;
    if (rf_we !== 1'b0 || md_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got we=%0b rdy=%0b want 0/1", rf_we, md_ready);
    end
  endtask

  task automatic test_md_drain();
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h1234;
    tick();
    md_valid = 1'b0;
    total++;
    if (md_ready !== 1'b0 || hold_busy !== 1'b1 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL md_capture got rdy=%0b hb=%0b we=%0b want 0/1/0", md_ready, hold_busy, rf_we);
    end
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234 || hold_busy !== 1'b0) begin
      bad++;
      $display("FAIL md_drain got we=%0b a=%0d d=%h hb=%0b want 1/7/1234/0",
               rf_we, rf_waddr, rf_wdata, hold_busy);
    end
    tick();
    total++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234) begin
      bad++;
      $display("FAIL idle_hold_value got we=%0b a=%0d d=%h want 0/7/1234", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_back_to_back();
    Regfile_weW = 1'b1; writeRegAddrW = 5'd1; resultW = 32'h10;
    tick();
    writeRegAddrW = 5'd2; resultW = 32'h20;
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h10) begin
      bad++;
      $display("FAIL b2b_first got we=%0b a=%0d d=%h want 1/1/10", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    idle();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h20) begin
      bad++;
      $display("FAIL b2b_second got we=%0b a=%0d d=%h want 1/2/20", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_starve();
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77;
    tick();
    idle();
    Regfile_weW = 1'b1; writeRegAddrW = 5'd3; resultW = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAA || hold_busy !== 1'b1) begin
        bad++;
        $display("FAIL starve_pipe_win[%0d] got we=%0b a=%0d d=%h hb=%0b want 1/3/aa/1",
                 i, rf_we, rf_waddr, rf_wdata, hold_busy);
      end
    end
`ifdef WB_STARVE_GUARD_EN
    total++;
    if (wb_stall !== 1'b1) begin
      bad++;
      $display("FAIL starve_stall got %0b want 1", wb_stall);
    end
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77 || wb_stall !== 1'b0 ||
        hold_busy !== 1'b0) begin
      bad++;
      $display("FAIL starve_drain got we=%0b a=%0d d=%h st=%0b hb=%0b want 1/7/77/0/0",
               rf_we, rf_waddr, rf_wdata, wb_stall, hold_busy);
    end
    tick();
    idle();
    total++;
    if (rf_waddr !== 5'd3 || wb_stall !== 1'b0) begin
      bad++;
      $display("FAIL starve_replay got a=%0d st=%0b want 3/0", rf_waddr, wb_stall);
    end
`else
    total++;
    if (wb_stall !== 1'b0) begin
      bad++;
      $display("FAIL starve_stall got %0b want 0", wb_stall);
    end
    tick();
    idle();
    total++;
    if (rf_waddr !== 5'd3 || hold_busy !== 1'b1) begin
      bad++;
      $display("FAIL starve_wait got a=%0d hb=%0b want 3/1", rf_waddr, hold_busy);
    end
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77 || hold_busy !== 1'b0) begin
      bad++;
      $display("FAIL starve_idle_drain got we=%0b a=%0d d=%h hb=%0b want 1/7/77/0",
               rf_we, rf_waddr, rf_wdata, hold_busy);
    end
`endif
    tick();
  endtask

  task automatic test_supersede();
    Regfile_weW = 1'b1; writeRegAddrW = 5'd9; resultW = 32'h99;
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'h11;
    tick();
    idle();
    Regfile_weW = 1'b1; writeRegAddrW = 5'd5; resultW = 32'h22;
    total++;
    if (hold_busy !== 1'b1 || rf_waddr !== 5'd9) begin
      bad++;
      $display("FAIL sup_hold got hb=%0b a=%0d want 1/9", hold_busy, rf_waddr);
    end
    tick();
    idle();
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h22 || hold_busy !== 1'b0) begin
      bad++;
      $display("FAIL sup_write got we=%0b a=%0d d=%h hb=%0b want 1/5/22/0",
               rf_we, rf_waddr, rf_wdata, hold_busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (rf_we !== 1'b0 || rf_wdata !== 32'h22) begin
        bad++;
        $display("FAIL sup_no_late[%0d] got we=%0b d=%h want 0/22", i, rf_we, rf_wdata);
      end
    end
  endtask

  task automatic test_zero();
    Regfile_weW = 1'b1; writeRegAddrW = 5'd0; resultW = 32'hFF;
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hEE;
    #1;
    total++;
    if (md_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_ready got %0b want 1", md_ready);
    end
    tick();
    idle();
    total++;
    if (rf_we !== 1'b0 || hold_busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_write got we=%0b hb=%0b want 0/0", rf_we, hold_busy);
    end
    tick();
    total++;
    if (rf_we !== 1'b0 || hold_busy !== 1'b0 || md_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_after got we=%0b hb=%0b rdy=%0b want 0/0/1", rf_we, hold_busy, md_ready);
    end
  endtask

  task automatic test_reset_mid();
    Regfile_weW = 1'b1; writeRegAddrW = 5'd3; resultW = 32'h33;
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h9999;
    tick();
    md_valid = 1'b0;
    total++;
    if (hold_busy !== 1'b1 || rf_we !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre got hb=%0b we=%0b want 1/1", hold_busy, rf_we);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({rf_we, rf_waddr, rf_wdata, wb_stall, hold_busy} !== 40'd0 || md_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_async got we=%0b a=%0d d=%h st=%0b hb=%0b rdy=%0b want 0s/rdy 1",
               rf_we, rf_waddr, rf_wdata, wb_stall, hold_busy, md_ready);
    end
    idle();
    tick();
    #2 rst = 1'b1;
    tick();
    total++;
    if (md_ready !== 1'b1 || rf_we !== 1'b0 || hold_busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_release got rdy=%0b we=%0b hb=%0b want 1/0/0", md_ready, rf_we, hold_busy);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    test_reset();
    test_md_drain();
    test_back_to_back();
    test_starve();
    test_supersede();
    test_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
